// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART interrupt-path constants and clear-priority helper
package uart_pkg;

    localparam int IIR_RLS  = 0;
    localparam int IIR_RDA  = 1;
    localparam int IIR_THRE = 2;
    localparam int IIR_CTI  = 3;

    localparam int LSR_OE = 0;
    localparam int LSR_PE = 1;
    localparam int LSR_FE = 2;
    localparam int LSR_BI = 3;

    localparam logic [3:0] CLR_NONE = 4'b0000;
    localparam logic [3:0] CLR_RLS  = 4'b0001;
    localparam logic [3:0] CLR_RDA  = 4'b0010;
    localparam logic [3:0] CLR_THRE = 4'b0100;
    localparam logic [3:0] CLR_CTI  = 4'b1000;

    typedef enum logic [1:0] {
        PRIO_RLS  = 2'd0,
        PRIO_RDA  = 2'd1,
        PRIO_CTI  = 2'd2,
        PRIO_THRE = 2'd3
    } clr_prio_e;

    // Service order is LSR > RDA > CTI > THRE; returns a single one-hot bit.
    function automatic logic [3:0] clr_pick(input logic [3:0] pend);
        logic [3:0] pick;
        pick = CLR_NONE;
        if (pend[IIR_RLS])       pick = CLR_RLS;
        else if (pend[IIR_RDA])  pick = CLR_RDA;
        else if (pend[IIR_CTI])  pick = CLR_CTI;
        else if (pend[IIR_THRE]) pick = CLR_THRE;
        return pick;
    endfunction

endpackage

// File: rtl/uart_rx_timeout.sv
// rtl/uart_rx_timeout.sv - RX idle bit counter and character-timeout flag
module uart_rx_timeout
    import uart_pkg::*;
#(
    parameter int RX_FIFO_DEPTH = 32,
    parameter int TIMEOUT_CHARS = 4
) (
    input  logic                             clk_i,
    input  logic                             rstn_i,
    input  logic                             i_rx_valid,
    input  logic                             i_rbr_rd,
    input  logic [$clog2(RX_FIFO_DEPTH):0]   i_rx_elements,
    input  logic                             i_bit_tick,
    input  logic [3:0]                       i_char_bits,
    output logic                             o_cti
);

    localparam int CNT_W = $clog2(TIMEOUT_CHARS * 12) + 1;

    logic [CNT_W-1:0] r_count;
    logic             r_cti;
    logic [CNT_W-1:0] w_limit;
    logic             w_restart;

    // Limit follows char_bits_i live so a format change applies mid-count.
    assign w_limit   = CNT_W'(TIMEOUT_CHARS) * CNT_W'(i_char_bits);
    assign w_restart = i_rx_valid | i_rbr_rd | (i_rx_elements == '0);

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            r_count <= '0;
            r_cti   <= 1'b0;
        end else if (w_restart) begin
            r_count <= '0;
            r_cti   <= 1'b0;
        end else begin
            if (i_bit_tick && (r_count < w_limit))
                r_count <= r_count + 1'b1;
            if (r_count >= w_limit)
                r_cti <= 1'b1;
        end
    end

    assign o_cti = r_cti;

endmodule

// File: rtl/uart_int_service.sv
// rtl/uart_int_service.sv - UART interrupt service: error latch, CTI and clear arbiter
module uart_int_service
    import uart_pkg::*;
#(
    parameter int RX_FIFO_DEPTH = 32,
    parameter int TIMEOUT_CHARS = 4
) (
    input  logic                             clk_i,
    input  logic                             rstn_i,
    input  logic                             iir_rd_i,
    input  logic                             lsr_rd_i,
    input  logic                             rbr_rd_i,
    input  logic                             thr_wr_i,
    input  logic                             rx_valid_i,
    input  logic                             rx_overrun_i,
    input  logic                             rx_parity_i,
    input  logic                             rx_frame_i,
    input  logic                             rx_break_i,
    input  logic [$clog2(RX_FIFO_DEPTH):0]   rx_elements_i,
    input  logic                             bit_tick_i,
    input  logic [3:0]                       char_bits_i,
    input  logic [3:0]                       iir_i,
    output logic [3:0]                       lsr_err_o,
    output logic                             error_o,
    output logic                             cti_o,
    output logic [3:0]                       clr_int_o
);

    logic [3:0] r_lsr_err;
    logic [3:0] r_pend;
    logic [3:0] r_clr;
    logic [3:0] w_err_set;
    logic [3:0] w_req;
    logic [3:0] w_all;
    logic [3:0] w_pick;

    always_comb begin
        w_err_set         = '0;
        w_err_set[LSR_OE] = rx_overrun_i;
        w_err_set[LSR_PE] = rx_parity_i;
        w_err_set[LSR_FE] = rx_frame_i;
        w_err_set[LSR_BI] = rx_break_i;
    end

    // New error pulses override a simultaneous LSR read for their own bit.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i)
            r_lsr_err <= '0;
        else
            r_lsr_err <= (lsr_rd_i ? 4'b0000 : r_lsr_err) | w_err_set;
    end

    assign lsr_err_o = r_lsr_err;
    assign error_o   = |r_lsr_err;

    always_comb begin
        w_req           = '0;
        w_req[IIR_RLS]  = lsr_rd_i & iir_i[IIR_RLS];
        w_req[IIR_RDA]  = rbr_rd_i & iir_i[IIR_RDA];
        w_req[IIR_THRE] = (iir_rd_i & iir_i[IIR_THRE]) | thr_wr_i;
        w_req[IIR_CTI]  = rbr_rd_i & iir_i[IIR_CTI];
    end

    // Requests join the pending set in the same cycle so an idle arbiter answers next clock.
    assign w_all  = r_pend | w_req;
    assign w_pick = clr_pick(w_all);

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            r_pend <= '0;
            r_clr  <= CLR_NONE;
        end else begin
            r_pend <= w_all & ~w_pick;
            r_clr  <= w_pick;
        end
    end

    assign clr_int_o = r_clr;

    uart_rx_timeout #(
        .RX_FIFO_DEPTH (RX_FIFO_DEPTH),
        .TIMEOUT_CHARS (TIMEOUT_CHARS)
    ) u_rx_timeout (
        .clk_i         (clk_i),
        .rstn_i        (rstn_i),
        .i_rx_valid    (rx_valid_i),
        .i_rbr_rd      (rbr_rd_i),
        .i_rx_elements (rx_elements_i),
        .i_bit_tick    (bit_tick_i),
        .i_char_bits   (char_bits_i),
        .o_cti         (cti_o)
    );

endmodule

// File: tb/tb_uart_int_service.sv
// tb/tb_uart_int_service.sv - directed and randomized bench for uart_int_service
module tb_uart_int_service;

    localparam int DEPTH = 32;
    localparam int TCH   = 4;

    logic       clk_i = 1'b0;
    logic       rstn_i = 1'b0;
    logic       iir_rd_i = 0, lsr_rd_i = 0, rbr_rd_i = 0, thr_wr_i = 0;
    logic       rx_valid_i = 0, rx_overrun_i = 0, rx_parity_i = 0, rx_frame_i = 0, rx_break_i = 0;
    logic [5:0] rx_elements_i = '0;
    logic       bit_tick_i = 0;
    logic [3:0] char_bits_i = 4'd10;
    logic [3:0] iir_i = '0;
    logic [3:0] lsr_err_o;
    logic       error_o;
    logic       cti_o;
    logic [3:0] clr_int_o;

    int checks = 0;
    int errors = 0;

    // Reference state: error flags, idle tick count, CTI flag, set of pending clears.
    logic [3:0] m_err;
    int         m_cnt;
    logic       m_cti;
    logic [3:0] m_pend;
    logic [3:0] m_clr;

    always #5 clk_i = ~clk_i;

    uart_int_service #(.RX_FIFO_DEPTH(DEPTH), .TIMEOUT_CHARS(TCH)) dut (
        .clk_i(clk_i), .rstn_i(rstn_i),
        .iir_rd_i(iir_rd_i), .lsr_rd_i(lsr_rd_i), .rbr_rd_i(rbr_rd_i), .thr_wr_i(thr_wr_i),
        .rx_valid_i(rx_valid_i), .rx_overrun_i(rx_overrun_i), .rx_parity_i(rx_parity_i),
        .rx_frame_i(rx_frame_i), .rx_break_i(rx_break_i), .rx_elements_i(rx_elements_i),
        .bit_tick_i(bit_tick_i), .char_bits_i(char_bits_i), .iir_i(iir_i),
        .lsr_err_o(lsr_err_o), .error_o(error_o), .cti_o(cti_o), .clr_int_o(clr_int_o)
    );

    task automatic chk(input string tag, input logic [3:0] got, input logic [3:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %b expected %b", tag, got, exp);
        end
    endtask

    task automatic check_model();
        chk("lsr_err", lsr_err_o, m_err);
        chk("error", {3'b0, error_o}, {3'b0, m_err != 4'b0});
        chk("cti", {3'b0, cti_o}, {3'b0, m_cti});
        chk("clr_int", clr_int_o, m_clr);
    endtask

    task automatic model_reset();
        m_err = '0; m_cnt = 0; m_cti = 0; m_pend = '0; m_clr = '0;
    endtask

    // One clock: predict from spec rules, advance, compare, drop pulse inputs.
    task automatic tick();
        logic [3:0] n_err, req, all;
        int         lim, n_cnt;
        logic       n_cti, restart;
        int         order [4] = '{0, 1, 3, 2};
        n_err = lsr_rd_i ? 4'b0 : m_err;
        n_err |= {rx_break_i, rx_frame_i, rx_parity_i, rx_overrun_i};
        lim = TCH * int'(char_bits_i);
        restart = rx_valid_i || rbr_rd_i || (rx_elements_i == 0);
        n_cnt = restart ? 0 : ((bit_tick_i && m_cnt < lim) ? m_cnt + 1 : m_cnt);
        n_cti = restart ? 1'b0 : (m_cti || m_cnt >= lim);
        req[0] = lsr_rd_i && iir_i[0];
        req[1] = rbr_rd_i && iir_i[1];
        req[2] = (iir_rd_i && iir_i[2]) || thr_wr_i;
        req[3] = rbr_rd_i && iir_i[3];
        all = m_pend | req;
        m_clr = '0;
        foreach (order[k]) begin
            if (m_clr == 0 && all[order[k]]) begin
                m_clr[order[k]] = 1'b1;
                all[order[k]] = 1'b0;
            end
        end
        m_pend = all;
        m_err = n_err; m_cnt = n_cnt; m_cti = n_cti;
        @(posedge clk_i);
        #1;
        check_model();
        {iir_rd_i, lsr_rd_i, rbr_rd_i, thr_wr_i, rx_valid_i} = '0;
        {rx_overrun_i, rx_parity_i, rx_frame_i, rx_break_i, bit_tick_i} = '0;
    endtask

    task automatic async_reset();
        #2;
        rstn_i = 1'b0;
        #1;
        model_reset();
        chk("rst_async_lsr", lsr_err_o, 4'b0);
        chk("rst_async_clr", clr_int_o, 4'b0);
        chk("rst_async_cti", {3'b0, cti_o}, 4'b0);
        @(posedge clk_i);
        #1;
        check_model();
        rstn_i = 1'b1;
    endtask

    initial begin
        model_reset();
        repeat (2) @(posedge clk_i);
        #1;
        check_model();
        rstn_i = 1'b1;
        tick();

        // Error latching
        rx_parity_i = 1; tick();
        chk("parity_set", lsr_err_o, 4'b0010);
        chk("parity_error_o", {3'b0, error_o}, 4'b0001);
        lsr_rd_i = 1; tick();
        chk("lsr_rd_clear", lsr_err_o, 4'b0000);
        rx_overrun_i = 1; tick();
        rx_frame_i = 1; lsr_rd_i = 1; tick();
        chk("frame_wins", lsr_err_o, 4'b0100);

        // Timeout at 10 bits x 4 chars = 40 ticks
        char_bits_i = 4'd10; rx_elements_i = 6'd3; rx_valid_i = 1; tick();
        for (int i = 0; i < 40; i++) begin bit_tick_i = 1; tick(); end
        chk("cti_not_yet", {3'b0, cti_o}, 4'b0);
        tick();
        chk("cti_set", {3'b0, cti_o}, 4'b0001);
        rbr_rd_i = 1; tick();
        chk("cti_rbr_clear", {3'b0, cti_o}, 4'b0);
        for (int i = 0; i < 39; i++) begin bit_tick_i = 1; tick(); end
        tick();
        chk("cti_restarted", {3'b0, cti_o}, 4'b0);

        // Suppressed with empty FIFO, then restart at tick 39
        rx_elements_i = 6'd0;
        for (int i = 0; i < 100; i++) begin bit_tick_i = 1; tick(); end
        chk("cti_empty", {3'b0, cti_o}, 4'b0);
        rx_elements_i = 6'd3; rx_valid_i = 1; tick();
        for (int i = 0; i < 39; i++) begin bit_tick_i = 1; tick(); end
        rx_valid_i = 1; bit_tick_i = 1; tick();
        for (int i = 0; i < 39; i++) begin bit_tick_i = 1; tick(); end
        tick();
        chk("cti_39_restart", {3'b0, cti_o}, 4'b0);
        bit_tick_i = 1; tick();
        tick();
        chk("cti_after_40", {3'b0, cti_o}, 4'b0001);

        // Clear arbitration
        iir_i = 4'b0111; lsr_rd_i = 1; rbr_rd_i = 1; thr_wr_i = 1; tick();
        chk("arb_0", clr_int_o, 4'b0001);
        iir_i = 4'b0000; tick();
        chk("arb_1", clr_int_o, 4'b0010);
        tick();
        chk("arb_2", clr_int_o, 4'b0100);
        tick();
        chk("arb_3", clr_int_o, 4'b0000);

        // THRE via IIR read
        iir_i = 4'b0100; iir_rd_i = 1; tick();
        chk("thre_pulse", clr_int_o, 4'b0100);
        iir_i = 4'b0010; iir_rd_i = 1; tick();
        chk("thre_none", clr_int_o, 4'b0000);

        // Reset mid-count with pending clears
        for (int i = 0; i < 5; i++) begin bit_tick_i = 1; tick(); end
        iir_i = 4'b0111; lsr_rd_i = 1; rbr_rd_i = 1; thr_wr_i = 1; rx_break_i = 1; tick();
        async_reset();
        iir_i = 4'b0000;
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("post_rst_quiet", clr_int_o, 4'b0000);
        end

        // Randomized traffic against the model
        for (int i = 0; i < 3000; i++) begin
            rx_valid_i   = ($urandom_range(0, 15) == 0);
            rx_overrun_i = ($urandom_range(0, 19) == 0);
            rx_parity_i  = ($urandom_range(0, 19) == 0);
            rx_frame_i   = ($urandom_range(0, 19) == 0);
            rx_break_i   = ($urandom_range(0, 19) == 0);
            lsr_rd_i     = ($urandom_range(0, 9) == 0);
            rbr_rd_i     = ($urandom_range(0, 40) == 0);
            iir_rd_i     = ($urandom_range(0, 7) == 0);
            thr_wr_i     = ($urandom_range(0, 9) == 0);
            bit_tick_i   = ($urandom_range(0, 1) == 0);
            iir_i        = 4'($urandom);
            if ($urandom_range(0, 59) == 0)
                rx_elements_i = ($urandom_range(0, 3) == 0) ? 6'd0 : 6'($urandom_range(1, 32));
            if ($urandom_range(0, 199) == 0)
                char_bits_i = 4'($urandom_range(7, 12));
            tick();
            if (i == 1500) async_reset();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_int_service.md
Name: uart_int_service

Overview:
- Service/acknowledge side of the UART interrupt path.
- Consumes receiver line events and the current IIR, and register-access strobes from the APB decoder.
- Produces the sticky line-status error flag, the character-timeout indication (CTI) and one-hot interrupt-clear pulses for the interrupt controller.
- Sits between the APB register file, the UART receiver and the interrupt controller.

Parameters:
- RX_FIFO_DEPTH, 32, RX FIFO depth; rx_elements_i width is $clog2(RX_FIFO_DEPTH)+1.
- TIMEOUT_CHARS, 4, character times of RX idle before CTI asserts.

Ports:
- clk_i  in  1  clock
- rstn_i  in  1  asynchronous active-low reset
- iir_rd_i  in  1  single-cycle pulse: APB read of IIR
- lsr_rd_i  in  1  single-cycle pulse: APB read of LSR
- rbr_rd_i  in  1  single-cycle pulse: APB read of RBR (pops RX FIFO)
- thr_wr_i  in  1  single-cycle pulse: APB write of THR
- rx_valid_i  in  1  pulse: receiver pushed one character
- rx_overrun_i, rx_parity_i, rx_frame_i, rx_break_i  in  1 each  receiver error pulses
- rx_elements_i  in  $clog2(RX_FIFO_DEPTH)+1  RX FIFO fill level
- bit_tick_i  in  1  one pulse per UART bit period
- char_bits_i  in  4  bits per frame (start+data+parity+stop), legal range 7..12
- iir_i  in  4  current IIR from the interrupt controller
- lsr_err_o  out  4  sticky {BI,FE,PE,OE}
- error_o  out  1  OR of lsr_err_o
- cti_o  out  1  character timeout indication
- clr_int_o  out  4  one-hot interrupt-clear pulse

Behaviour:
- Reset values: lsr_err_o=0, error_o=0, cti_o=0, clr_int_o=0; timeout counter=0; pending clears=0.
- Error latching:
  - Each error pulse sets its lsr_err_o bit on the next clock.
  - lsr_rd_i clears all four bits on the next clock.
  - An error pulse coincident with lsr_rd_i wins: that bit is 1 after the edge, the other bits are cleared.
  - error_o is combinational OR of the registered bits.
- Timeout counter:
  - Width ceil(log2(TIMEOUT_CHARS*12))+1.
  - Reset to 0 on rx_valid_i, rbr_rd_i, or rx_elements_i==0.
  - Otherwise increments on bit_tick_i, saturating at limit = TIMEOUT_CHARS*char_bits_i (computed at counter width).
  - cti_o is registered: set the cycle after count==limit with rx_elements_i!=0.
  - cti_o clears on rbr_rd_i, rx_valid_i, or rx_elements_i==0 (next clock).
  - A char_bits_i change while counting takes effect immediately; if count already exceeds the new limit, cti_o sets.
- Clear requests, each registered into a pending bit:
  - LSR: lsr_rd_i & iir_i[0].
  - RDA: rbr_rd_i & iir_i[1].
  - THRE: (iir_rd_i & iir_i[2]) | thr_wr_i.
  - CTI: rbr_rd_i & iir_i[3].
- Clear issue:
  - Each cycle, the highest-priority pending bit (LSR > RDA > CTI > THRE) drives clr_int_o as a single-cycle one-hot pulse, and that pending bit clears.
  - Other pending bits wait one cycle each.
  - clr_int_o is never multi-hot.
  - Latency from strobe to pulse: 1 cycle when nothing is pending.
  - A new request for an already-pending bit merges (no double pulse).
- Reset mid-operation: all state returns to reset values immediately (asynchronous); no pulse is emitted after rstn_i deasserts unless a new strobe arrives.

Decomposition:
- Shared uart_pkg holds:
  - IIR bit index constants (IIR_RLS=0, IIR_RDA=1, IIR_THRE=2, IIR_CTI=3).
  - LSR error bit indices.
  - clr_int one-hot localparams.
- One natural sub-module: uart_rx_timeout (counter plus cti_o register), instantiated once. The error latch and clear arbiter stay in the top.

Test Plan:
- Reset: hold rstn_i low mid-count with pending clears -> all outputs 0; after release no clr_int_o pulse for 10 cycles.
- Errors:
  - rx_parity_i pulse -> lsr_err_o=4'b0010 and error_o=1 next cycle.
  - lsr_rd_i -> 4'b0000.
  - rx_frame_i coincident with lsr_rd_i -> lsr_err_o=4'b0100.
- Timeout: char_bits_i=10, rx_elements_i=3, no activity -> cti_o=1 the cycle after the 40th bit_tick_i; rbr_rd_i -> cti_o=0 next cycle and the counter restarts.
- Timeout suppressed: rx_elements_i=0 for 100 bit ticks -> cti_o stays 0; rx_valid_i at tick 39 -> no CTI until 40 further ticks.
- Clear arbitration: iir_i=4'b0111 with lsr_rd_i, rbr_rd_i and thr_wr_i in the same cycle -> clr_int_o=0001, then 0010, then 0100 on consecutive cycles, then 0000.
- THRE: iir_rd_i with iir_i=4'b0100 -> clr_int_o=0100 one cycle later; iir_rd_i with iir_i=4'b0010 -> no pulse.
